bank_rr_arb: RTL and testbench

BANK_RR_ARB -- requirements
Module: bank_rr_arb

---
 rtl/tcdm_interconnect_pkg.sv | 12 +
 rtl/bank_rr_arb_if.sv | 30 +++
 rtl/rr_prio_sel.sv | 37 +++
 rtl/bank_rr_arb.sv | 101 ++++++++++
 tb/tb_bank_rr_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_interconnect_pkg.sv
// Shared constants for the TCDM interconnect blocks.
// Provides the conflict-counter width and the select-index width helper.
package tcdm_interconnect_pkg;

  localparam int unsigned ConflictCntWidth = 16;

  // An index into n masters needs at least one bit, even for n == 1.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_rr_arb_if.sv
// Bundle of the requester-side and bank-side handshake signals of one bank arbiter.
// The arb modport is the arbiter's view; env is the view of whatever drives it.
interface bank_rr_arb_if
  import tcdm_interconnect_pkg::*;
#(
  parameter  int unsigned NumIn        = 8,
  parameter  int unsigned ReqDataWidth = 32,
  localparam int unsigned SelW         = sel_width(NumIn)
);

  logic                                 flush;
  logic [NumIn-1:0]                     req;
  logic [NumIn-1:0][ReqDataWidth-1:0]   data;
  logic [NumIn-1:0]                     gnt;
  logic                                 bank_req;
  logic                                 bank_gnt;
  logic [ReqDataWidth-1:0]              bank_data;
  logic [SelW-1:0]                      sel;

  modport arb (
    input  flush, req, data, bank_gnt,
    output gnt, bank_req, bank_data, sel
  );

  modport env (
    output flush, req, data, bank_gnt,
    input  gnt, bank_req, bank_data, sel
  );

endinterface

// File: rtl/rr_prio_sel.sv
// Circular priority search: first set bit of req_i at or above start_i, wrapping
// from NumIn-1 back to 0. idx_o falls back to start_i when nothing is requested.
module rr_prio_sel
  import tcdm_interconnect_pkg::*;
#(
  parameter  int unsigned NumIn = 8,
  localparam int unsigned SelW  = sel_width(NumIn)
) (
  input  logic [NumIn-1:0] req_i,
  input  logic [SelW-1:0]  start_i,
  output logic [SelW-1:0]  idx_o,
  output logic             empty_o
);

  localparam int unsigned PosW = SelW + 1;

  logic [PosW-1:0] pos;
  logic            found;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through the block leaves a value unassigned (no latch inferred).
  always_comb begin
    idx_o   = start_i;
    empty_o = ~|req_i;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NumIn; k++) begin
      pos = {1'b0, start_i} + PosW'(k);
      if (pos >= PosW'(NumIn)) pos = pos - PosW'(NumIn);
      if (!found && req_i[pos[SelW-1:0]]) begin
        found = 1'b1;
        idx_o = pos[SelW-1:0];
      end
    end
  end

endmodule

// File: rtl/bank_rr_arb.sv
// Round-robin arbiter funnelling NumIn masters onto one bank with zero-cycle grant.
// Define BANK_RR_ARB_STATS_EN to add the saturating conflict_cnt_o output.
module bank_rr_arb
  import tcdm_interconnect_pkg::*;
#(
  parameter  int unsigned NumIn        = 8,
  parameter  int unsigned ReqDataWidth = 32,
  localparam int unsigned SelW         = sel_width(NumIn)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumIn-1:0]                   req_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0] data_i,
  output logic [NumIn-1:0]                   gnt_o,
  output logic                               req_o,
  input  logic                               gnt_i,
  output logic [ReqDataWidth-1:0]            data_o,
  output logic [SelW-1:0]                    sel_o
`ifdef BANK_RR_ARB_STATS_EN
  ,
  output logic [ConflictCntWidth-1:0]        conflict_cnt_o
`endif
);

  if (NumIn == 1) begin : g_pass
    assign req_o  = req_i[0];
    assign gnt_o  = gnt_i;
    assign data_o = data_i[0];
    assign sel_o  = '0;
  end else begin : g_arb
    logic [SelW-1:0] rr_d, rr_q;
    logic [SelW-1:0] sel;
    logic [SelW-1:0] sel_inc;
    logic            empty;

    rr_prio_sel #(.NumIn(NumIn)) u_prio_sel (
      .req_i   (req_i),
      .start_i (rr_q),
      .idx_o   (sel),
      .empty_o (empty)
    );

    // req_o looks only at the requests, so a bank that derives gnt_i from
    // req_o cannot close a combinational loop through this block.
    assign req_o   = ~empty;
    assign sel_inc = (sel == SelW'(NumIn - 1)) ? '0 : sel + SelW'(1);

    always_comb begin
      gnt_o      = '0;
      gnt_o[sel] = gnt_i & req_i[sel];
      data_o     = data_i[sel];
      sel_o      = sel;
    end

    // Flush wins over an accepted transfer; the grant itself still goes out.
    always_comb begin
      rr_d = rr_q;
      if (flush_i)             rr_d = '0;
      else if (req_o && gnt_i) rr_d = sel_inc;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
    end
  end

`ifdef BANK_RR_ARB_STATS_EN
  logic [ConflictCntWidth-1:0] conflict_cnt_d, conflict_cnt_q;
  logic                        conflict;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign conflict = |(req_i & (req_i - NumIn'(1)));

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (flush_i)                                conflict_cnt_d = '0;
    else if (conflict && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (NumIn > 0) else $error("bank_rr_arb: NumIn must be at least 1");
    if (rst_ni && gnt_i) begin
      assert ($onehot0(gnt_o)) else $error("bank_rr_arb: gnt_o not onehot0");
    end
  end
`endif

endmodule

// File: tb/tb_bank_rr_arb.sv
// Self-checking bench for bank_rr_arb: directed table (NumIn=8), random vs. model,
// reset/flush corners, a NumIn=5 instance, and the stats counter when compiled in.
module tb_bank_rr_arb;
  import tcdm_interconnect_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bank_rr_arb_if #(.NumIn(8), .ReqDataWidth(32)) bus8 ();
  bank_rr_arb_if #(.NumIn(5), .ReqDataWidth(32)) bus5 ();

`ifdef BANK_RR_ARB_STATS_EN
  logic [ConflictCntWidth-1:0] cnt8;
  logic [ConflictCntWidth-1:0] cnt5;
`endif

  bank_rr_arb #(.NumIn(8), .ReqDataWidth(32)) dut8 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (bus8.flush),
    .req_i   (bus8.req),
    .data_i  (bus8.data),
    .gnt_o   (bus8.gnt),
    .req_o   (bus8.bank_req),
    .gnt_i   (bus8.bank_gnt),
    .data_o  (bus8.bank_data),
    .sel_o   (bus8.sel)
`ifdef BANK_RR_ARB_STATS_EN
    ,
    .conflict_cnt_o (cnt8)
`endif
  );

  bank_rr_arb #(.NumIn(5), .ReqDataWidth(32)) dut5 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (bus5.flush),
    .req_i   (bus5.req),
    .data_i  (bus5.data),
    .gnt_o   (bus5.gnt),
    .req_o   (bus5.bank_req),
    .gnt_i   (bus5.bank_gnt),
    .data_o  (bus5.bank_data),
    .sel_o   (bus5.sel)
`ifdef BANK_RR_ARB_STATS_EN
    ,
    .conflict_cnt_o (cnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       gnt;
    logic       flush;
    logic       exp_req;
    logic [7:0] exp_gnt;
    int         exp_sel;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0011_0101;
  endfunction

  // Reference: the winner is the requester with the smallest forward distance from rr.
  function automatic int model_pick(input logic [7:0] req, input int rr, input int n);
    int best  = rr;
    int bestd = n;
    for (int i = 0; i < n; i++) begin
      int d = (i - rr + n) % n;
      if (req[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic add_vec(input logic [7:0] req, input logic gnt, input logic flush,
                         input logic exp_req, input logic [7:0] exp_gnt, input int exp_sel);
    vec_t v;
    v.req = req; v.gnt = gnt; v.flush = flush;
    v.exp_req = exp_req; v.exp_gnt = exp_gnt; v.exp_sel = exp_sel;
    tbl.push_back(v);
  endtask

  task automatic apply8(input logic [7:0] req, input logic gnt, input logic flush);
    @(negedge clk);
    bus8.req      = req;
    bus8.bank_gnt = gnt;
    bus8.flush    = flush;
    #2;
  endtask

  task automatic apply5(input logic [4:0] req, input logic gnt, input logic flush);
    @(negedge clk);
    bus5.req      = req;
    bus5.bank_gnt = gnt;
    bus5.flush    = flush;
    #2;
  endtask

  logic [31:0] rdata [8];
  int          rr8;
  int          esel;
  logic [7:0]  egnt;
  logic [7:0]  rreq;
  logic        rgnt;
  logic        rflush;

  initial begin
    rst_n = 1'b0;
    bus8.req = '0; bus8.bank_gnt = 1'b0; bus8.flush = 1'b0;
    bus5.req = '0; bus5.bank_gnt = 1'b0; bus5.flush = 1'b0;
    for (int i = 0; i < 8; i++) bus8.data[i] = pat(i);
    for (int i = 0; i < 5; i++) bus5.data[i] = pat(i + 16);

    // Reset state
    #3;
    check("rst_sel", 32'(bus8.sel), 32'd0);
    check("rst_gnt", 32'(bus8.gnt), 32'd0);
    check("rst_req", 32'(bus8.bank_req), 32'd0);
    check("rst_sel5", 32'(bus5.sel), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) add_vec(8'hFF, 1'b1, 1'b0, 1'b1, 8'(1 << i), i);
    add_vec(8'hFF, 1'b1, 1'b0, 1'b1, 8'h01, 0);
    add_vec(8'h10, 1'b1, 1'b0, 1'b1, 8'h10, 4);
    add_vec(8'h90, 1'b1, 1'b0, 1'b1, 8'h80, 7);
    add_vec(8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 0);
    for (int i = 0; i < 3; i++) add_vec(8'h04, 1'b0, 1'b0, 1'b1, 8'h00, 2);
    add_vec(8'h04, 1'b1, 1'b0, 1'b1, 8'h04, 2);
    add_vec(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3);
    add_vec(8'h08, 1'b1, 1'b1, 1'b1, 8'h08, 3);
    add_vec(8'hFF, 1'b1, 1'b0, 1'b1, 8'h01, 0);

    foreach (tbl[i]) begin
      apply8(tbl[i].req, tbl[i].gnt, tbl[i].flush);
      check($sformatf("tbl%0d_req", i),  32'(bus8.bank_req), 32'(tbl[i].exp_req));
      check($sformatf("tbl%0d_gnt", i),  32'(bus8.gnt),      32'(tbl[i].exp_gnt));
      check($sformatf("tbl%0d_sel", i),  32'(bus8.sel),      32'(tbl[i].exp_sel));
      check($sformatf("tbl%0d_data", i), bus8.bank_data,     pat(tbl[i].exp_sel));
    end

    // Random traffic against the model; pointer is 1 after the table.
    rr8 = 1;
    for (int c = 0; c < 400; c++) begin
      rreq   = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rreq = rreq & 8'($urandom);
      rgnt   = ($urandom_range(0, 3) != 0);
      rflush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rdata[i]     = $urandom;
        bus8.data[i] = rdata[i];
      end
      bus8.req = rreq; bus8.bank_gnt = rgnt; bus8.flush = rflush;
      #2;
      esel = model_pick(rreq, rr8, 8);
      egnt = (rgnt && rreq[esel]) ? 8'(1 << esel) : 8'h00;
      check("rnd_req",  32'(bus8.bank_req), 32'(rreq != 0));
      check("rnd_gnt",  32'(bus8.gnt), 32'(egnt));
      check("rnd_sel",  32'(bus8.sel), 32'(esel));
      check("rnd_data", bus8.bank_data, rdata[esel]);
      if (rflush)                   rr8 = 0;
      else if (rreq != 0 && rgnt)   rr8 = (esel + 1) % 8;
    end
    for (int i = 0; i < 8; i++) bus8.data[i] = pat(i);

    // Reset mid-transfer: pointer advanced, then async reset drops it to 0.
    apply8(8'hFF, 1'b1, 1'b0);
    apply8(8'hFF, 1'b1, 1'b0);
    apply8(8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    bus8.bank_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_sel", 32'(bus8.sel), 32'd0);
    check("midrst_gnt", 32'(bus8.gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply8(8'hFF, 1'b1, 1'b0);
    check("postrst_gnt0", 32'(bus8.gnt), 32'h01);
    apply8(8'hFF, 1'b1, 1'b0);
    check("postrst_gnt1", 32'(bus8.gnt), 32'h02);
    apply8(8'h00, 1'b0, 1'b0);

    // NumIn=5: non-power-of-two wrap, then flush after index 2.
    for (int k = 0; k < 6; k++) begin
      apply5(5'h1F, 1'b1, 1'b0);
      check($sformatf("n5_sel%0d", k), 32'(bus5.sel), 32'(k % 5));
      check($sformatf("n5_gnt%0d", k), 32'(bus5.gnt), 32'(1 << (k % 5)));
      check($sformatf("n5_data%0d", k), bus5.bank_data, pat((k % 5) + 16));
    end
    apply5(5'h1F, 1'b1, 1'b0);
    check("n5_pre1", 32'(bus5.sel), 32'd1);
    apply5(5'h1F, 1'b1, 1'b0);
    check("n5_pre2", 32'(bus5.sel), 32'd2);
    apply5(5'h1F, 1'b0, 1'b1);
    check("n5_flush_sel", 32'(bus5.sel), 32'd3);
    check("n5_flush_gnt", 32'(bus5.gnt), 32'd0);
    apply5(5'h1F, 1'b1, 1'b0);
    check("n5_after_flush", 32'(bus5.gnt), 32'h01);
    apply5(5'h00, 1'b0, 1'b0);

`ifdef BANK_RR_ARB_STATS_EN
    apply8(8'h00, 1'b0, 1'b1);
    apply8(8'h00, 1'b0, 1'b0);
    check("cnt_clear", 32'(cnt8), 32'd0);
    apply8(8'h03, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    check("cnt_sat", 32'(cnt8), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    check("cnt_hold", 32'(cnt8), 32'hFFFF);
    apply8(8'h02, 1'b1, 1'b0);
    apply8(8'h00, 1'b0, 1'b0);
    check("cnt_rr2", 32'(bus8.sel), 32'd2);
    rst_n = 1'b0;
    #1;
    check("cnt_rst", 32'(cnt8), 32'd0);
    check("cnt_rst_sel", 32'(bus8.sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
